oram_path_flush_engine: RTL
===========================

// Module: oram_path_flush_engine
// PURPOSE
// - Synthesizable eviction (write-direction) counterpart of the ORAM path fetch.
// - Given a leaf pos_star, walks the root->leaf path.
// - Pushes each valid tuple one level down when its pos bit agrees with the path and the child bucket has a free slot.
// - Sits beside the fetch/put_back datapath and owns the tree-bucket memory port while busy.
// PARAMETERS
// - TREE_DEPTH  14  tree levels (root=1, leaf=TREE_DEPTH); node numbers 1..2^TREE_DEPTH-1, address = node-1
// - K           3   tuples per bucket
// - VAL_W       32  block value width (BYTE_WIDTH*BYTES_PER_BLOCK)
// - Derived: TUPLE_W = 1+(TREE_DEPTH-1)+TREE_DEPTH+VAL_W, packed {empty_n,pos,b_number,val}
// - Derived: BUCKET_W = K*TUPLE_W, slot 0 in LSBs
// - Derived: N_PUSH = TREE_DEPTH*(TREE_DEPTH-1)/2
// PORTS
// - clk        in   1               single clock, rising edge
// - rst_n      in   1               synchronous, active-low reset
// - start      in   1               request flush; accepted when start && ready
// - pos_star   in   TREE_DEPTH-1    leaf to flush toward; latched on accept
// - ready      out  1               high only in IDLE
// - done       out  1               one-cycle pulse at end of flush
// - blocked_cnt out 16              path-matching tuples that found no free child slot, this flush
// - mem_addr   out  TREE_DEPTH      bucket address (node-1)
// - mem_rd_en  out  1               bucket read; mem_rdata valid exactly 1 cycle later
// - mem_rdata  in   BUCKET_W        read bucket
// - mem_wr_en  out  1               bucket write of mem_wdata at mem_addr, same cycle
// - mem_wdata  out  BUCKET_W        bucket to write
// BEHAVIOUR
// - Reset values: ready=1, done=0, blocked_cnt=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0; state IDLE.
// - Loop order: for i=TREE_DEPTH-1 downto 1, for d=i..TREE_DEPTH-1: push(d); N_PUSH pushes total.
// - push(d): higher node H = level-d node on the path; child L = (H<<1)|pos_star[d-1].
//   - Path node: start at 1; each step node=(node<<1)|pos_star[step]; pos bit 0 selects the root's child.
// - Per-push states, 5 cycles, no idle gaps between pushes:
//   - RD_HI: rd H.
//   - RD_LO: rd L; latch H from rdata.
//   - MERGE: latch L from rdata; compute merge, register results.
//   - WR_LO: wr L.
//   - WR_HI: wr H.
// - Merge, sequential semantics: for hi slot j=0..K-1, if empty_n=1 and pos[d-1]==pos_star[d-1]:
//   - Copy the tuple into the lowest-index L slot with empty_n=0.
//   - Clear only the empty_n bit of H slot j; other fields are retained.
//   - If no free L slot exists, the tuple stays in H and blocked_cnt increments (saturates at 16'hFFFF).
//   - Tuples with empty_n=0 or a non-matching bit are untouched.
// - Both buckets are always written back, even when unchanged.
// - Accept: blocked_cnt clears to 0 and pos_star is latched on the accepting edge. State goes RD_HI.
// - After the last WR_HI, state DONE for 1 cycle (done=1, ready=0), then IDLE.
// - Timing: done is high during the cycle starting 5*N_PUSH edges after the accepting edge.
// - start while busy is ignored and not queued. mem_rd_en and mem_wr_en are never both high.
// - blocked_cnt holds its value after done until the next accept.
// - Reset mid-flush: the next cycle is IDLE with rd/wr low and no done pulse. Tree may be partially flushed; the caller reinitializes.
// TESTING (TREE_DEPTH=4, K=3, VAL_W=8; N_PUSH=6; done at edge 30)
// - Empty tree, pos_star=5 -> 12 reads, 12 writes, buckets unchanged, done at edge 30 only, blocked_cnt=0.
// - Root slot0 = tuple{pos=5,b_number=7,val=8'hA5}, pos_star=5 -> tuple ends in addr 12 slot0. All other slots have empty_n=0.
// - Root tuple pos=4, pos_star=5 -> bit0 mismatch, tuple remains at addr 0, blocked_cnt=0.
// - Addr 5 and addr 12 both full of pos=5 tuples; root tuple pos=5; pos_star=5 -> root tuple moves to addr 2, blocked_cnt=10.
// - rst_n low at edge 7 of a flush -> next cycle ready=1, rd_en=wr_en=0, done never pulses.
// - start pulsed at edge 10 of a flush -> ignored; exactly one done, at edge 30.

Source files
------------

// File: rtl/oram_path_flush_engine.sv
// Path eviction engine: walks the root->leaf path of pos_star and pushes matching tuples one level down.
// Each push is a 5-cycle RD_HI/RD_LO/MERGE/WR_LO/WR_HI sequence; start is only accepted in IDLE.
module oram_path_flush_engine #(
  parameter  int TREE_DEPTH = 14,
  parameter  int K          = 3,
  parameter  int VAL_W      = 32,
  localparam int TUPLE_W    = 1 + (TREE_DEPTH - 1) + TREE_DEPTH + VAL_W,
  localparam int BUCKET_W   = K * TUPLE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [TREE_DEPTH-2:0] pos_star,
  output logic                  ready,
  output logic                  done,
  output logic [15:0]           blocked_cnt,
  output logic [TREE_DEPTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [BUCKET_W-1:0]   mem_rdata,
  output logic                  mem_wr_en,
  output logic [BUCKET_W-1:0]   mem_wdata
);

  localparam int LW = $clog2(TREE_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_HI, S_RD_LO, S_MERGE, S_WR_LO, S_WR_HI, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [TREE_DEPTH-2:0] pos_star_q;
  logic [LW-1:0]         lvl_i_q, lvl_d_q, dsel;
  logic [BUCKET_W-1:0]   hi_q, hi_new_q, lo_new_q;
  logic [15:0]           blocked_q;
  logic [TREE_DEPTH-1:0] hi_node, lo_node;
  logic                  path_bit, last_push;
  logic [BUCKET_W-1:0]   hi_m, lo_m;
  logic [15:0]           blk_inc;
  logic [16:0]           blk_sum;
  logic [TUPLE_W-1:0]    tup;
  logic [TREE_DEPTH-2:0] tup_pos;
  logic                  placed;

  assign dsel      = lvl_d_q - LW'(1);
  assign path_bit  = pos_star_q[dsel];
  assign last_push = (lvl_d_q == LW'(TREE_DEPTH - 1)) && (lvl_i_q == LW'(1));

  // Level-d node on the path: root is node 1, each step appends one pos_star bit.
  always_comb begin
    hi_node = TREE_DEPTH'(1);
    for (int s = 0; s < TREE_DEPTH - 1; s++) begin
      if (s < int'(dsel)) hi_node = {hi_node[TREE_DEPTH-2:0], pos_star_q[s]};
    end
    lo_node = {hi_node[TREE_DEPTH-2:0], path_bit};
  end

  always_comb begin
    hi_m    = hi_q;
    lo_m    = mem_rdata;
    blk_inc = '0;
    tup     = '0;
    tup_pos = '0;
    placed  = 1'b0;
    for (int j = 0; j < K; j++) begin
      tup     = hi_m[j*TUPLE_W +: TUPLE_W];
      tup_pos = tup[TUPLE_W-2 -: TREE_DEPTH-1];
      if (tup[TUPLE_W-1] && (tup_pos[dsel] == path_bit)) begin
        placed = 1'b0;
        for (int k = 0; k < K; k++) begin
          if (!placed && !lo_m[k*TUPLE_W + TUPLE_W - 1]) begin
            lo_m[k*TUPLE_W +: TUPLE_W] = tup;
            placed = 1'b1;
          end
        end
        // Only the valid bit is dropped; stale fields stay in the slot.
        if (placed) hi_m[j*TUPLE_W + TUPLE_W - 1] = 1'b0;
        else        blk_inc = blk_inc + 16'd1;
      end
    end
    blk_sum = {1'b0, blocked_q} + {1'b0, blk_inc};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RD_HI;
      S_RD_HI: state_d = S_RD_LO;
      S_RD_LO: state_d = S_MERGE;
      S_MERGE: state_d = S_WR_LO;
      S_WR_LO: state_d = S_WR_HI;
      S_WR_HI: state_d = last_push ? S_DONE : S_RD_HI;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_star_q <= '0;
      lvl_i_q    <= LW'(TREE_DEPTH - 1);
      lvl_d_q    <= LW'(TREE_DEPTH - 1);
      hi_q       <= '0;
      hi_new_q   <= '0;
      lo_new_q   <= '0;
      blocked_q  <= '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        pos_star_q <= pos_star;
        lvl_i_q    <= LW'(TREE_DEPTH - 1);
        lvl_d_q    <= LW'(TREE_DEPTH - 1);
        blocked_q  <= '0;
      end
      if (state_q == S_RD_LO) hi_q <= mem_rdata;
      if (state_q == S_MERGE) begin
        hi_new_q  <= hi_m;
        lo_new_q  <= lo_m;
        blocked_q <= blk_sum[16] ? 16'hFFFF : blk_sum[15:0];
      end
      // Outer loop i counts down; inner d runs i..TREE_DEPTH-1.
      if (state_q == S_WR_HI && !last_push) begin
        if (lvl_d_q == LW'(TREE_DEPTH - 1)) begin
          lvl_i_q <= lvl_i_q - LW'(1);
          lvl_d_q <= lvl_i_q - LW'(1);
        end else begin
          lvl_d_q <= lvl_d_q + LW'(1);
        end
      end
    end
  end

  always_comb begin
    ready       = (state_q == S_IDLE);
    done        = (state_q == S_DONE);
    blocked_cnt = blocked_q;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wdata   = '0;
    case (state_q)
      S_RD_HI: begin mem_rd_en = 1'b1; mem_addr = hi_node - TREE_DEPTH'(1); end
      S_RD_LO: begin mem_rd_en = 1'b1; mem_addr = lo_node - TREE_DEPTH'(1); end
      S_WR_LO: begin
        mem_wr_en = 1'b1;
        mem_addr  = lo_node - TREE_DEPTH'(1);
        mem_wdata = lo_new_q;
      end
      S_WR_HI: begin
        mem_wr_en = 1'b1;
        mem_addr  = hi_node - TREE_DEPTH'(1);
        mem_wdata = hi_new_q;
      end
      default: ;
    endcase
  end

endmodule
